uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of the UART receiver. Captures each completed frame (`rx_done` rising edge with `rx_dout`) into a DEPTH-entry first-word-fall-through FIFO. Presents bytes to the host/bus side over a valid/ready handshake. Reports fill level, almost-full and a sticky overrun flag so that bursts arriving faster than the consumer drains them are absorbed or flagged, never silently corrupted.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo_core.sv | 63 ++++++
 rtl/uart_rx_fifo.sv | 99 +++++++++
 tb/tb_uart_rx_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame width, byte type and a constant clog2
// used to size pointers in the receive/transmit buffers.
package uart_pkg;

   localparam int UART_DBITS = 8;

   typedef logic [UART_DBITS-1:0] uart_byte_t;

   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
         result = result + 32'sd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Generic synchronous first-word-fall-through FIFO: storage, extended pointers,
// full/empty and fill level. The caller must not assert wr_en on a full FIFO unless rd_en is also set.
module sync_fifo_core
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      full,
   output logic                      empty,
   output logic [clog2(DEPTH):0]     level
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;

   // Pointer registers; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (clr) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (rd_en) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

   // Storage array; contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (wr_en && !clr) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
   assign empty   = (wr_ptr_r == rd_ptr_r);
   assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign level   = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: turns each rising edge of rx_done into a FIFO push,
// drops and flags bytes that arrive while full, and exposes a valid/ready read port.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DBITS    = UART_DBITS,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   rx_done,
   input  logic [DBITS-1:0]       rx_dout,
   output logic [DBITS-1:0]       rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [clog2(DEPTH):0]  level,
   output logic                   almost_full,
   output logic                   overrun,
   input  logic                   overrun_clr
);

   localparam int          AW        = clog2(DEPTH);
   localparam logic [AW:0] AF_THRESH = (AW + 1)'(AF_LEVEL);

   logic rx_done_q_r;
   logic overrun_r;
   logic push_s;
   logic pop_s;
   logic wr_en_s;
   logic rd_en_s;
   logic drop_s;
   logic full_s;
   logic empty_s;

   sync_fifo_core #(
      .WIDTH (DBITS),
      .DEPTH (DEPTH)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .wr_en   (wr_en_s),
      .wr_data (rx_dout),
      .rd_en   (rd_en_s),
      .rd_data (rd_data),
      .full    (full_s),
      .empty   (empty_s),
      .level   (level)
   );

   // Edge detect, drop-on-full policy and flush gating.
   always_comb begin
      push_s  = rx_done & ~rx_done_q_r;
      pop_s   = ~empty_s & rd_ready;
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
      drop_s  = 1'b0;
      if (clr) begin
         wr_en_s = 1'b0;
         rd_en_s = 1'b0;
         drop_s  = 1'b0;
      end else begin
         rd_en_s = pop_s;
         wr_en_s = push_s & (~full_s | pop_s);
         drop_s  = push_s & full_s & ~pop_s;
      end
   end

   // Previous rx_done; starts high so a level held through reset is not a new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_done_q_r <= 1'b1;
      end else begin
         rx_done_q_r <= rx_done;
      end
   end

   // Sticky overrun: a drop in the same cycle beats a software clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_r <= 1'b0;
      end else if (clr) begin
         overrun_r <= 1'b0;
      end else if (drop_s) begin
         overrun_r <= 1'b1;
      end else if (overrun_clr) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

   assign overrun     = overrun_r;
   assign rd_valid    = ~empty_s;
   assign almost_full = (level >= AF_THRESH);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int DEPTH = 16;
   localparam int AF    = 12;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       rx_done;
   logic [7:0] rx_dout;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [4:0] level;
   logic       almost_full;
   logic       overrun;
   logic       overrun_clr;

   uart_byte_t mq[$];
   bit         m_ovr  = 1'b0;
   bit         m_prev = 1'b1;
   bit         cmp_en = 1'b0;
   int         checks   = 0;
   int         failures = 0;

   uart_rx_fifo #(.DBITS(8), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .rx_done     (rx_done),
      .rx_dout     (rx_dout),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .level       (level),
      .almost_full (almost_full),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue updated from the inputs seen at each edge.
   always @(posedge clk or negedge rst_n) begin
      bit push;
      bit pop;
      bit accept;
      if (!rst_n) begin
         mq.delete();
         m_ovr  = 1'b0;
         m_prev = 1'b1;
      end else begin
         push   = rx_done && !m_prev;
         pop    = rd_ready && (mq.size() > 0);
         accept = push && ((mq.size() < DEPTH) || pop);
         if (clr) begin
            mq.delete();
            m_ovr = 1'b0;
         end else begin
            if (pop) void'(mq.pop_front());
            if (accept) mq.push_back(rx_dout);
            if (push && !accept) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
         end
         m_prev = rx_done;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
         check("level", 32'(level), 32'(mq.size()));
         check("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
         check("overrun", 32'(overrun), 32'(m_ovr));
         if (mq.size() > 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_dout = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; rx_done = 1'b1; rx_dout = 8'h00;
      rd_ready = 1'b0; overrun_clr = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      cmp_en = 1'b1;
      check("reset_level", 32'(level), 32'd0);
      check("reset_valid", 32'(rd_valid), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      check("reset_af", 32'(almost_full), 32'd0);

      // rx_done held high out of reset must not push.
      rst_n = 1'b1;
      repeat (5) tick();
      check("held_done_level", 32'(level), 32'd0);
      check("held_done_valid", 32'(rd_valid), 32'd0);
      rx_done = 1'b0;
      tick();

      push_byte(8'hA5); push_byte(8'h3C); push_byte(8'hFF);
      check("three_level", 32'(level), 32'd3);
      check("three_head", 32'(rd_data), 32'hA5);
      check("model_size3", 32'(mq.size()), 32'd3);
      rd_ready = 1'b1;
      check("read0", 32'(rd_data), 32'hA5); tick();
      check("read1", 32'(rd_data), 32'h3C); tick();
      check("read2", 32'(rd_data), 32'hFF); tick();
      rd_ready = 1'b0;
      check("drained_valid", 32'(rd_valid), 32'd0);
      check("drained_level", 32'(level), 32'd0);

      for (int i = 0; i < 16; i++) begin
         push_byte(8'(i));
         if (i == 10) check("af_at11", 32'(almost_full), 32'd0);
         if (i == 11) check("af_at12", 32'(almost_full), 32'd1);
      end
      check("full_level", 32'(level), 32'd16);
      push_byte(8'h55);
      check("drop_overrun", 32'(overrun), 32'd1);
      check("drop_level", 32'(level), 32'd16);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_seq", 32'(rd_data), 32'(i));
         tick();
      end
      rd_ready = 1'b0;
      check("drain_empty", 32'(rd_valid), 32'd0);

      // Flush with a coincident push while overrun is still set.
      check("pre_clr_overrun", 32'(overrun), 32'd1);
      for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
      check("five_level", 32'(level), 32'd5);
      rx_dout = 8'h99; rx_done = 1'b1; clr = 1'b1;
      tick();
      clr = 1'b0; rx_done = 1'b0;
      tick();
      check("clr_level", 32'(level), 32'd0);
      check("clr_overrun", 32'(overrun), 32'd0);
      check("clr_valid", 32'(rd_valid), 32'd0);

      // Full FIFO: push coincident with pop is accepted.
      for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i));
      rx_dout = 8'h77; rx_done = 1'b1; rd_ready = 1'b1;
      tick();
      rx_done = 1'b0; rd_ready = 1'b0;
      tick();
      check("pp_full_level", 32'(level), 32'd16);
      check("pp_full_overrun", 32'(overrun), 32'd0);
      rx_dout = 8'h66; rx_done = 1'b1; overrun_clr = 1'b1;
      tick();
      rx_done = 1'b0; overrun_clr = 1'b0;
      tick();
      check("set_beats_clear", 32'(overrun), 32'd1);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("pp_drain", 32'(rd_data), (i < 15) ? 32'(8'h11 + i) : 32'h77);
         tick();
      end
      rd_ready = 1'b0;
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("overrun_cleared", 32'(overrun), 32'd0);

      // Streaming through the wrap point.
      rd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rx_dout = 8'($urandom);
         rx_done = 1'b1;
         tick();
         check("stream_level_le1", 32'(level <= 5'd1), 32'd1);
         rx_done = 1'b0;
         tick();
         check("stream_level_le1", 32'(level <= 5'd1), 32'd1);
      end
      rd_ready = 1'b0;
      tick();

      // Random traffic: slow drain first, then fast drain.
      for (int i = 0; i < 800; i++) begin
         rx_done     = 1'($urandom_range(0, 1));
         rx_dout     = 8'($urandom);
         rd_ready    = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr         = ($urandom_range(0, 99) == 0);
         overrun_clr = ($urandom_range(0, 15) == 0);
         tick();
      end
      rx_done = 1'b0; rd_ready = 1'b0; clr = 1'b0; overrun_clr = 1'b0;
      tick();

      // Asynchronous reset in the middle of a fill.
      push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
      check("prefill_level", 32'(level), 32'd3);
      rx_dout = 8'h04; rx_done = 1'b1;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_level", 32'(level), 32'd0);
      check("async_rst_valid", 32'(rd_valid), 32'd0);
      check("async_rst_af", 32'(almost_full), 32'd0);
      check("async_rst_overrun", 32'(overrun), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_no_push", 32'(level), 32'd0);
      rx_done = 1'b0;
      repeat (2) tick();
      cmp_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
